led_strip_driver: RTL

//  Parametrised multi-channel WS2812-style serial LED driver; next generation of the single-strip LED controller.

---
 rtl/led_strip_pkg.sv | 33 +++
 rtl/led_bit_timer.sv | 31 +++
 rtl/led_strip_driver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/led_strip_pkg.sv
// Shared definitions for the multi-channel WS2812-style LED strip driver:
// FSM state type, default timing constants and a width helper.
package led_strip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BIT_HI = 2'd1,
    ST_BIT_LO = 2'd2,
    ST_LATCH  = 2'd3
  } state_t;

  // Defaults assume a 25 MHz clock.
  localparam int DEF_CHANNELS      = 2;
  localparam int DEF_LED_CNT       = 3;
  localparam int DEF_BYTES_PER_LED = 3;
  localparam int DEF_T0H_CYC       = 10;
  localparam int DEF_T1H_CYC       = 20;
  localparam int DEF_TBIT_CYC      = 31;
  localparam int DEF_RESET_CYC     = 1250;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r = r + 1;
    return r;
  endfunction

  // Minimum width of one bit so single-entry ranges still yield legal vectors.
  function automatic int idx_w(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Shared bit-phase counter for all strip channels; emits strobes on the last
// cycle of the '0' high time, the '1' high time and the whole bit period.
module led_bit_timer
  import led_strip_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_hi_end0,
  output logic o_hi_end1,
  output logic o_bit_end
);

  localparam int PW = idx_w(TBIT_CYC);

  logic [PW-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (reset || !i_run || o_bit_end) r_phase <= '0;
    else                              r_phase <= r_phase + PW'(1);
  end

  assign o_hi_end0 = i_run && (r_phase == PW'(T0H_CYC - 1));
  assign o_hi_end1 = i_run && (r_phase == PW'(T1H_CYC - 1));
  assign o_bit_end = i_run && (r_phase == PW'(TBIT_CYC - 1));

endmodule

// File: rtl/led_strip_driver.sv
// Multi-channel WS2812-style serial LED driver with banked frame buffer.
// Optional macro LED_STRIP_BRIGHTNESS_EN adds a global brightness_i scaler.
module led_strip_driver
  import led_strip_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int LED_CNT       = DEF_LED_CNT,
  parameter int BYTES_PER_LED = DEF_BYTES_PER_LED,
  parameter int T0H_CYC       = DEF_T0H_CYC,
  parameter int T1H_CYC       = DEF_T1H_CYC,
  parameter int TBIT_CYC      = DEF_TBIT_CYC,
  parameter int RESET_CYC     = DEF_RESET_CYC,
  localparam int CH_BYTES     = LED_CNT * BYTES_PER_LED,
  localparam int CH_W         = idx_w(CHANNELS),
  localparam int IDX_W        = idx_w(CH_BYTES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  output logic                wr_ready_o,
  input  logic [CH_W-1:0]     wr_ch_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [7:0]          wr_data_i,
`ifdef LED_STRIP_BRIGHTNESS_EN
  input  logic [7:0]          brightness_i,
`endif
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam int LW = idx_w(RESET_CYC);

  state_t           r_state, w_next;
  logic [7:0]       r_buf   [CHANNELS][CH_BYTES];
  logic [7:0]       r_shift [CHANNELS];
  logic [2:0]       r_bit;
  logic [IDX_W-1:0] r_byte;
  logic [LW-1:0]    r_latch;
  logic             r_load, r_hi1, r_done;
  logic             w_run, w_hi_end0, w_hi_end1, w_bit_end;
  logic             w_last_byte, w_last_bit, w_latch_end;
  logic             w_ch_ok, w_idx_ok, w_wr, w_fetch;
  logic [IDX_W-1:0] w_fetch_idx;

`ifdef LED_STRIP_BRIGHTNESS_EN
  logic [7:0] r_bright;

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start_i) r_bright <= brightness_i;
  end

  function automatic logic [7:0] send_byte(input logic [7:0] d, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(d) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction
`else
  function automatic logic [7:0] send_byte(input logic [7:0] d, input logic [7:0] b);
    return d | (b & 8'h00);
  endfunction

  logic [7:0] r_bright;
  assign r_bright = 8'hFF;
`endif

  led_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_run     (w_run),
    .o_hi_end0 (w_hi_end0),
    .o_hi_end1 (w_hi_end1),
    .o_bit_end (w_bit_end)
  );

  // A fully populated index space has no out-of-range codes to filter.
  if (CHANNELS == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (wr_ch_i < CH_W'(CHANNELS));
  end
  if (CH_BYTES == (1 << IDX_W)) begin : g_idx_full
    assign w_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign w_idx_ok = (wr_idx_i < IDX_W'(CH_BYTES));
  end

  assign w_run       = (r_state == ST_BIT_HI) || (r_state == ST_BIT_LO);
  assign w_last_byte = (r_byte == IDX_W'(CH_BYTES - 1));
  assign w_last_bit  = w_last_byte && (r_bit == 3'd7);
  assign w_latch_end = (r_latch == LW'(RESET_CYC - 1));
  assign w_wr        = wr_en_i && wr_ready_o && w_ch_ok && w_idx_ok;
  assign w_fetch     = r_load || (w_bit_end && (r_bit == 3'd7) && !w_last_byte);
  assign w_fetch_idx = r_load ? '0 : (w_last_byte ? r_byte : r_byte + IDX_W'(1));

  always_comb begin
    w_next     = r_state;
    busy_o     = 1'b1;
    wr_ready_o = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy_o     = 1'b0;
        wr_ready_o = 1'b1;
        if (start_i) w_next = ST_BIT_HI;
      end
      ST_BIT_HI: if (w_hi_end0) w_next = ST_BIT_LO;
      ST_BIT_LO: if (w_bit_end) w_next = w_last_bit ? ST_LATCH : ST_BIT_HI;
      ST_LATCH:  if (w_latch_end) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_byte  <= '0;
      r_latch <= '0;
      r_load  <= 1'b0;
      r_hi1   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_LATCH) && w_latch_end;
      // First byte is loaded one cycle late so a write on the start cycle is seen.
      r_load  <= (r_state == ST_IDLE) && start_i;
      if (r_state == ST_IDLE) begin
        r_bit  <= '0;
        r_byte <= '0;
      end else if (w_bit_end) begin
        r_bit <= r_bit + 3'd1;
        if (r_bit == 3'd7 && !w_last_byte) r_byte <= r_byte + IDX_W'(1);
      end
      if (r_state == ST_LATCH) r_latch <= r_latch + LW'(1);
      else                     r_latch <= '0;
      if (w_hi_end1 || !w_run)                     r_hi1 <= 1'b0;
      else if (r_state == ST_BIT_HI && w_hi_end0)  r_hi1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < CH_BYTES; i++)
          r_buf[c][i] <= '0;
    end else if (w_wr) begin
      r_buf[wr_ch_i][wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_fetch)        r_shift[c] <= send_byte(r_buf[c][w_fetch_idx], r_bright);
      else if (w_bit_end) r_shift[c] <= {r_shift[c][6:0], 1'b0};
    end
  end

  // Lines share the common '0' high time; '1' bits extend into BIT_LO.
  always_comb begin
    led_o = '0;
    for (int c = 0; c < CHANNELS; c++)
      led_o[c] = (r_state == ST_BIT_HI) ||
                 ((r_state == ST_BIT_LO) && r_hi1 && r_shift[c][7]);
  end

  assign done_o = r_done;

endmodule
